// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game-round controller: sequence generation, playback and input checking
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse, begins a new game (accepted in IDLE/WIN/LOSE)
//   rnd_ready   in   random source ready, rnd_value valid while high (sampled in GEN only)
//   rnd_value   in   random colour 0..3
//   btn_valid   in   one-cycle pulse, player pressed a button (sampled in WAIT_IN only)
//   btn_value   in   colour pressed
//   led_on      out  playback LED enable (registered)
//   led_value   out  colour being played back (registered, held while dark)
//   level       out  current sequence length
//   busy        out  generating or playing back
//   wait_input  out  waiting for player presses
//   win         out  game won
//   game_over   out  game lost
module simon_sequencer #(
    parameter int MAX_LEN        = 32,
    parameter int ON_CYCLES      = 4,
    parameter int OFF_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnd_ready,
    input  logic [1:0] rnd_value,
    input  logic       btn_valid,
    input  logic [1:0] btn_value,
    output logic       led_on,
    output logic [1:0] led_value,
    output logic [7:0] level,
    output logic       busy,
    output logic       wait_input,
    output logic       win,
    output logic       game_over
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = $clog2(PMAX + 1);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST   = CW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LEN_MAX    = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GEN      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_WAIT_IN  = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;
    localparam logic [2:0] S_LOSE     = 3'd6;

    logic [2:0]    state;
    logic [7:0]    len;
    logic [7:0]    idx;
    logic [TW-1:0] timer;
    logic [CW-1:0] phase;
    logic [1:0]    seq [MAX_LEN];

    logic [7:0] idx_inc;
    logic [7:0] len_m1;
    logic       gen_take;

    assign idx_inc  = idx + 8'd1;
    assign len_m1   = len - 8'd1;
    assign gen_take = (state == S_GEN) && rnd_ready;

    // Sequence memory is not reset; only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (!rst && gen_take) begin
            seq[len[AW-1:0]] <= rnd_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len       <= 8'd0;
            idx       <= 8'd0;
            timer     <= '0;
            phase     <= '0;
            led_on    <= 1'b0;
            led_value <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state <= S_GEN;
                        len   <= 8'd0;
                        idx   <= 8'd0;
                        timer <= '0;
                        phase <= '0;
                    end
                end
                S_GEN: begin
                    if (rnd_ready) begin
                        len    <= len + 8'd1;
                        idx    <= 8'd0;
                        phase  <= '0;
                        state  <= S_SHOW_ON;
                        led_on <= 1'b1;
                        // In the first round seq[0] is being written this same edge.
                        led_value <= (len == 8'd0) ? rnd_value : seq[0];
                    end
                end
                S_SHOW_ON: begin
                    if (phase == ON_LAST) begin
                        phase  <= '0;
                        led_on <= 1'b0;
                        state  <= S_SHOW_OFF;
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (phase == OFF_LAST) begin
                        phase <= '0;
                        if (idx == len_m1) begin
                            state <= S_WAIT_IN;
                            idx   <= 8'd0;
                            timer <= '0;
                        end else begin
                            idx       <= idx_inc;
                            state     <= S_SHOW_ON;
                            led_on    <= 1'b1;
                            led_value <= seq[idx_inc[AW-1:0]];
                        end
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                S_WAIT_IN: begin
                    // A press wins over a timeout landing on the same cycle.
                    if (btn_valid) begin
                        if (btn_value == seq[idx[AW-1:0]]) begin
                            if (idx != len_m1) begin
                                idx   <= idx_inc;
                                timer <= '0;
                            end else if (len == LEN_MAX) begin
                                state <= S_WIN;
                            end else begin
                                state <= S_GEN;
                            end
                        end else begin
                            state <= S_LOSE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state <= S_LOSE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign level      = len;
    assign busy       = (state == S_GEN) || (state == S_SHOW_ON) || (state == S_SHOW_OFF);
    assign wait_input = (state == S_WAIT_IN);
    assign win        = (state == S_WIN);
    assign game_over  = (state == S_LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - self-checking bench for simon_sequencer
module tb_simon_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rnd_ready;
    logic [1:0] rnd_value;
    logic       btn_valid;
    logic [1:0] btn_value;
    logic       led_on;
    logic [1:0] led_value;
    logic [7:0] level;
    logic       busy;
    logic       wait_input;
    logic       win;
    logic       game_over;

    always #5 clk = ~clk;

    simon_sequencer #(
        .MAX_LEN       (4),
        .ON_CYCLES     (4),
        .OFF_CYCLES    (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rnd_ready (rnd_ready),
        .rnd_value (rnd_value),
        .btn_valid (btn_valid),
        .btn_value (btn_value),
        .led_on    (led_on),
        .led_value (led_value),
        .level     (level),
        .busy      (busy),
        .wait_input(wait_input),
        .win       (win),
        .game_over (game_over)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [1:0] exp_q [$];
    logic [1:0] model_seq [4];
    logic [1:0] wv [4];

    typedef struct {
        logic        start;
        logic        rnd_ready;
        logic [1:0]  rnd_value;
        logic        btn_valid;
        logic [1:0]  btn_value;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [14:0] outs();
        return {led_on, led_value, level, busy, wait_input, win, game_over};
    endfunction

    function automatic vec_t mkv(input logic s, input logic rr, input logic [1:0] rv,
                                 input logic bv, input logic [1:0] bval,
                                 input logic lo, input logic [1:0] lv, input logic [7:0] lvl,
                                 input logic b, input logic w, input logic wn, input logic go);
        vec_t v;
        v.start     = s;
        v.rnd_ready = rr;
        v.rnd_value = rv;
        v.btn_valid = bv;
        v.btn_value = bval;
        v.exp       = {lo, lv, lvl, b, w, wn, go};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; rnd_ready = 1'b0; rnd_value = 2'd0; btn_valid = 1'b0; btn_value = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outs", 32'(outs()), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] v);
        btn_valid = 1'b1;
        btn_value = v;
        tick();
        btn_valid = 1'b0;
        btn_value = 2'd0;
    endtask

    // Enter from GEN: feed one random value and follow playback up to WAIT_IN.
    task automatic play_round(input logic [1:0] v, input int len_r);
        int         cycles;
        logic       prev;
        logic [1:0] e;
        model_seq[len_r-1] = v;
        for (int i = 0; i < len_r; i++) exp_q.push_back(model_seq[i]);
        rnd_ready = 1'b1;
        rnd_value = v;
        tick();
        rnd_ready = 1'b0;
        rnd_value = 2'd0;
        check("round_level", 32'(level), len_r);
        cycles = 0;
        prev   = 1'b0;
        while (1) begin
            if (led_on && !prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_led_value", 32'(led_value), 32'(e));
                end
            end
            prev = led_on;
            if (wait_input || cycles >= 100) break;
            tick();
            cycles++;
        end
        check("round_cycles", cycles, len_r * 6);
        check("sb_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle with stray inputs, then a full first round cycle by cycle.
        vecs[0]  = mkv(0, 1, 2'd3, 0, 2'd0,  0, 2'd0, 8'd0, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 0, 2'd0, 1, 2'd1,  0, 2'd0, 8'd0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 1, 2'd2, 1, 2'd2,  0, 2'd0, 8'd0, 0, 0, 0, 0);
        vecs[3]  = mkv(0, 0, 2'd0, 0, 2'd0,  0, 2'd0, 8'd0, 0, 0, 0, 0);
        vecs[4]  = mkv(1, 0, 2'd0, 0, 2'd0,  0, 2'd0, 8'd0, 1, 0, 0, 0);
        vecs[5]  = mkv(0, 1, 2'd2, 0, 2'd0,  1, 2'd2, 8'd1, 1, 0, 0, 0);
        vecs[6]  = mkv(0, 0, 2'd0, 0, 2'd0,  1, 2'd2, 8'd1, 1, 0, 0, 0);
        vecs[7]  = mkv(0, 0, 2'd0, 0, 2'd0,  1, 2'd2, 8'd1, 1, 0, 0, 0);
        vecs[8]  = mkv(0, 0, 2'd0, 0, 2'd0,  1, 2'd2, 8'd1, 1, 0, 0, 0);
        vecs[9]  = mkv(0, 0, 2'd0, 0, 2'd0,  0, 2'd2, 8'd1, 1, 0, 0, 0);
        vecs[10] = mkv(0, 0, 2'd0, 0, 2'd0,  0, 2'd2, 8'd1, 1, 0, 0, 0);
        vecs[11] = mkv(0, 0, 2'd0, 0, 2'd0,  0, 2'd2, 8'd1, 0, 1, 0, 0);

        wv[0] = 2'd1; wv[1] = 2'd3; wv[2] = 2'd0; wv[3] = 2'd2;

        do_reset();
        for (int i = 0; i < 12; i++) begin
            start     = vecs[i].start;
            rnd_ready = vecs[i].rnd_ready;
            rnd_value = vecs[i].rnd_value;
            btn_valid = vecs[i].btn_valid;
            btn_value = vecs[i].btn_value;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        start = 1'b0; rnd_ready = 1'b0; btn_valid = 1'b0;

        // Full win through four rounds.
        do_reset();
        do_start();
        for (int r = 1; r <= 4; r++) begin
            play_round(wv[r-1], r);
            for (int i = 0; i < r; i++) begin
                press(wv[i]);
                if (i < r - 1) check("win_mid_wait", 32'(wait_input), 32'd1);
            end
            if (r < 4) begin
                check("win_next_gen", 32'(busy), 32'd1);
            end else begin
                check("win_flag", 32'(win), 32'd1);
                check("win_level", 32'(level), 32'd4);
            end
        end
        start = 1'b0;
        press(2'd1);
        tick();
        tick();
        check("win_hold", 32'(win), 32'd1);
        check("win_level_hold", 32'(level), 32'd4);

        // Wrong press in round 2, then restart.
        do_reset();
        do_start();
        play_round(2'd1, 1);
        press(2'd1);
        check("wrong_gen", 32'(busy), 32'd1);
        play_round(2'd3, 2);
        press(2'd1);
        check("wrong_first_ok", 32'(wait_input), 32'd1);
        press(2'd2);
        check("wrong_lose", 32'(game_over), 32'd1);
        check("wrong_level", 32'(level), 32'd2);
        tick();
        check("wrong_lose_hold", 32'(game_over), 32'd1);
        do_start();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_level", 32'(level), 32'd0);
        check("restart_go", 32'(game_over), 32'd0);

        // Timeout with no press.
        do_reset();
        do_start();
        play_round(2'd0, 1);
        repeat (15) tick();
        check("to_still_wait", 32'(wait_input), 32'd1);
        tick();
        check("to_lose", 32'(game_over), 32'd1);

        // Press on the last allowed cycle beats the timeout and restarts the timer.
        do_reset();
        do_start();
        play_round(2'd1, 1);
        press(2'd1);
        play_round(2'd2, 2);
        repeat (15) tick();
        check("late_pre_wait", 32'(wait_input), 32'd1);
        press(2'd1);
        check("late_press_wait", 32'(wait_input), 32'd1);
        check("late_press_nolose", 32'(game_over), 32'd0);
        repeat (15) tick();
        check("late_timer_reset", 32'(wait_input), 32'd1);
        press(2'd2);
        check("late_idx_adv", 32'(busy), 32'd1);
        check("late_level", 32'(level), 32'd2);

        // Reset during playback.
        do_reset();
        do_start();
        rnd_ready = 1'b1; rnd_value = 2'd3;
        tick();
        rnd_ready = 1'b0; rnd_value = 2'd0;
        tick();
        check("rstmid_led", 32'(led_on), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_outs", 32'(outs()), 32'd0);
        tick();
        check("rstmid_idle", 32'(outs()), 32'd0);

        // Stray btn_valid in SHOW_ON and rnd_ready in SHOW_OFF are ignored.
        do_reset();
        do_start();
        model_seq[0] = 2'd1;
        rnd_ready = 1'b1; rnd_value = 2'd1;
        tick();
        rnd_ready = 1'b0; rnd_value = 2'd0;
        check("ign_led_val", 32'(led_value), 32'd1);
        btn_valid = 1'b1; btn_value = 2'd2;
        tick();
        btn_valid = 1'b0; btn_value = 2'd0;
        tick();
        tick();
        check("ign_on_len", 32'(led_on), 32'd1);
        tick();
        check("ign_off", 32'(led_on), 32'd0);
        rnd_ready = 1'b1; rnd_value = 2'd0;
        tick();
        rnd_ready = 1'b0;
        check("ign_level_off", 32'(level), 32'd1);
        tick();
        check("ign_wait", 32'(wait_input), 32'd1);
        check("ign_level_wait", 32'(level), 32'd1);
        press(2'd1);
        check("ign_mem_ok", 32'(busy), 32'd1);
        check("ign_no_lose", 32'(game_over), 32'd0);
        play_round(2'd2, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
